wb_commit_queue: RTL and testbench
==================================

// Module: wb_commit_queue
// PURPOSE
//  Parametrised multi-lane writeback stage. Accepts in-order bundles of LANES results from MEM,
//  forms final values (PC+8 / ALU / OutB / extended load data) and holds them in a DEPTH-bundle
//  commit queue. The head bundle drives the regfile write ports; it drains only while wb_diswr is
//  low, so D-cache stalls no longer lose or block writeback.
// PARAMETERS
//  LANES   2   result lanes per bundle (1..4)
//  DATA_W  32  datapath width (32 only for load extension; other widths legal with wbsel!=3)
//  DEPTH   4   queue depth in bundles (power of 2, >=2)
//  NQ      2   forwarding query ports (used only with WB_QUEUE_FWD_EN)
// PORTS
//  clk        in   1              clock
//  resetn     in   1              asynchronous reset, active low
//  wb_flush   in   1              discard queue and current input
//  wb_diswr   in   1              hold head bundle; no RF writes this cycle
//  in_valid   in   1              bundle valid
//  in_ready   out  1              queue can accept a bundle
//  in_lane_v  in   LANES          per-lane valid inside bundle
//  in_pc      in   LANES*32       lane PC
//  in_alu     in   LANES*DATA_W   ALU result / load address
//  in_outb    in   LANES*DATA_W   OutB operand (MTC0/MTHI/MTLO paths)
//  in_dmout   in   LANES*32       raw D-cache word
//  in_ldtype  in   LANES*3        0 LW,1 LB,2 LBU,3 LH,4 LHU
//  in_wbsel   in   LANES*2        0 PC+8,1 ALU,2 OutB,3 load result
//  in_dst     in   LANES*5        destination register
//  in_rfwr    in   LANES          lane writes RF
//  wb_we      out  LANES          RF write enable per lane
//  wb_dst     out  LANES*5        RF write index
//  wb_data    out  LANES*DATA_W   RF write data
//  wb_pc      out  LANES*32       head-bundle PCs (debug trace)
//  q_count    out  $clog2(DEPTH)+1 bundles held
//  q_idx      in   NQ*5           forwarding query register index
//  q_hit      out  NQ             pending write to q_idx exists
//  q_data     out  NQ*DATA_W      youngest pending value for q_idx
// BEHAVIOUR
//  - Reset (resetn low, async): queue empty, head/tail ptrs 0, q_count 0; wb_we, wb_dst, wb_data,
//    wb_pc, q_hit, q_data all 0; in_ready 1 once reset releases.
//  - Push: in_valid & in_ready & !wb_flush at edge -> bundle stored at tail, tail++ (mod DEPTH).
//    Final value computed combinationally at enqueue; storage holds data, dst, we, pc per lane.
//  - Lane we stored = in_lane_v & in_rfwr & (dst!=0) & !(any higher lane j in bundle with same
//    store-we and dst) -> highest lane wins intra-bundle WAW.
//  - Load ext: byte = dmout[8*alu[1:0]+:8]; half = dmout[16*alu[1]+:16]; LB/LH sign, LBU/LHU zero;
//    LW whole word. Misaligned cases already trapped upstream; use alu bits as-is.
//  - WbSel 0 gives lane pc+8 (32-bit wrap).
//  - Drive: wb_* reflect head bundle combinationally; wb_we forced 0 when empty or wb_diswr.
//  - Pop: !empty & !wb_diswr & !wb_flush at edge -> head++. Latency: pushed at edge N, written to
//    RF in cycle N+1 if queue was empty and wb_diswr low.
//  - in_ready = (q_count < DEPTH); no pop-through when full. Push+pop same edge: count unchanged.
//  - wb_flush: at edge ptrs and count to 0; simultaneous push and pop ignored; wb_we low in the
//    flush cycle. Flush dominates everything except reset.
//  - Pointer wrap: DEPTH-1 -> 0; q_count distinguishes full from empty.
//  - Reset mid-operation: contents dropped, no spurious write after release.
// CONFIGURATION
//  WB_QUEUE_FWD_EN defined: per query, scan all held entries (and head) oldest->youngest, lanes
//  low->high; q_hit=1 and q_data=last match with we=1 and dst==q_idx!=0. Combinational, same cycle.
//  Not defined: compare logic absent; q_hit and q_data tied 0; q_idx unused.
// TESTING
//  1 Reset: resetn low mid-stream -> all outputs 0, q_count 0; after release in_ready=1.
//  2 LB: lane0 ldtype=1, wbsel=3, alu=0x..02, dmout=0x0080_0000, dst=5 -> next cycle wb_we[0]=1,
//    wb_dst=5, wb_data=0xFFFF_FF80; LBU same -> 0x0000_0080.
//  3 Backpressure: wb_diswr=1, push DEPTH bundles -> in_ready=0, q_count=DEPTH, wb_we=0; drop diswr
//    -> one bundle per cycle written in push order, in_ready=1 after first pop.
//  4 Flush: push with wb_flush=1 and 2 held bundles -> q_count=0 next cycle, pushed bundle never written.
//  5 WAW: lane0 and lane1 both dst=7 -> only wb_we[1]=1 with lane1 data; dst=0 -> wb_we=0.
//  6 FWD_EN: hold bundles writing r3=0x11 then r3=0x22, q_idx=3 -> q_hit=1, q_data=0x22;
//    q_idx=0 -> q_hit=0; without macro q_hit=0 always.

Source files
------------

// File: rtl/wb_commit_queue.sv
// rtl/wb_commit_queue.sv - multi-lane writeback commit queue (optional forwarding: WB_QUEUE_FWD_EN)
module wb_commit_queue #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int NQ     = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wb_flush,
    input  logic                       wb_diswr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES-1:0]           in_lane_v,
    input  logic [LANES*32-1:0]        in_pc,
    input  logic [LANES*DATA_W-1:0]    in_alu,
    input  logic [LANES*DATA_W-1:0]    in_outb,
    input  logic [LANES*32-1:0]        in_dmout,
    input  logic [LANES*3-1:0]         in_ldtype,
    input  logic [LANES*2-1:0]         in_wbsel,
    input  logic [LANES*5-1:0]         in_dst,
    input  logic [LANES-1:0]           in_rfwr,
    output logic [LANES-1:0]           wb_we,
    output logic [LANES*5-1:0]         wb_dst,
    output logic [LANES*DATA_W-1:0]    wb_data,
    output logic [LANES*32-1:0]        wb_pc,
    output logic [$clog2(DEPTH):0]     q_count,
    input  logic [NQ*5-1:0]            q_idx,
    output logic [NQ-1:0]              q_hit,
    output logic [NQ*DATA_W-1:0]       q_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] data_q [DEPTH][LANES];
    logic [DATA_W-1:0] data_d [DEPTH][LANES];
    logic [4:0]        dst_q  [DEPTH][LANES];
    logic [4:0]        dst_d  [DEPTH][LANES];
    logic [31:0]       pc_q   [DEPTH][LANES];
    logic [31:0]       pc_d   [DEPTH][LANES];
    logic [LANES-1:0]  we_q   [DEPTH];
    logic [LANES-1:0]  we_d   [DEPTH];

    logic [DATA_W-1:0] lane_val [LANES];
    logic [LANES-1:0]  lane_raw;
    logic [LANES-1:0]  lane_we;
    logic              empty;
    logic              push;
    logic              pop;

    // Sign/zero extension of the selected byte/half of the raw D-cache word.
    function automatic logic [31:0] load_ext(input logic [2:0] t, input logic [1:0] off,
                                             input logic [31:0] dm);
        logic [7:0]  by;
        logic [15:0] hw;
        by = dm[{off, 3'b000} +: 8];
        hw = off[1] ? dm[31:16] : dm[15:0];
        case (t)
            3'd1:    load_ext = {{24{by[7]}}, by};
            3'd2:    load_ext = {24'b0, by};
            3'd3:    load_ext = {{16{hw[15]}}, hw};
            3'd4:    load_ext = {16'b0, hw};
            default: load_ext = dm;
        endcase
    endfunction

    assign empty    = (cnt_q == '0);
    assign in_ready = (cnt_q < CNT_W'(DEPTH));
    assign push     = in_valid & in_ready & ~wb_flush;
    assign pop      = ~empty & ~wb_diswr & ~wb_flush;
    assign q_count  = cnt_q;

    // Final lane values and write enables; highest lane wins a same-bundle WAW.
    always_comb begin
        lane_raw = '0;
        lane_we  = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_val[l] = '0;
            case (in_wbsel[l*2 +: 2])
                2'd0:    lane_val[l] = DATA_W'(in_pc[l*32 +: 32] + 32'd8);
                2'd1:    lane_val[l] = in_alu[l*DATA_W +: DATA_W];
                2'd2:    lane_val[l] = in_outb[l*DATA_W +: DATA_W];
                default: lane_val[l] = DATA_W'(load_ext(in_ldtype[l*3 +: 3],
                                                        in_alu[l*DATA_W +: 2],
                                                        in_dmout[l*32 +: 32]));
            endcase
            lane_raw[l] = in_lane_v[l] & in_rfwr[l] & (in_dst[l*5 +: 5] != 5'd0);
        end
        for (int l = 0; l < LANES; l++) begin
            lane_we[l] = lane_raw[l];
            for (int j = l + 1; j < LANES; j++) begin
                if (lane_raw[j] && (in_dst[j*5 +: 5] == in_dst[l*5 +: 5])) begin
                    lane_we[l] = 1'b0;
                end
            end
        end
    end

    // Pointer/count update and enqueue into the tail slot; flush dominates.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        dst_d  = dst_q;
        pc_d   = pc_q;
        we_d   = we_q;
        if (wb_flush) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) begin
                for (int l = 0; l < LANES; l++) begin
                    data_d[tail_q][l] = lane_val[l];
                    dst_d[tail_q][l]  = in_dst[l*5 +: 5];
                    pc_d[tail_q][l]   = in_pc[l*32 +: 32];
                end
                we_d[tail_q] = lane_we;
                tail_d       = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                we_q[i] <= '0;
                for (int l = 0; l < LANES; l++) begin
                    data_q[i][l] <= '0;
                    dst_q[i][l]  <= '0;
                    pc_q[i][l]   <= '0;
                end
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            dst_q  <= dst_d;
            pc_q   <= pc_d;
            we_q   <= we_d;
        end
    end

    // Head bundle drives the RF ports; writes suppressed when empty, held or flushing.
    always_comb begin
        wb_we   = '0;
        wb_dst  = '0;
        wb_data = '0;
        wb_pc   = '0;
        for (int l = 0; l < LANES; l++) begin
            if (!empty) begin
                wb_we[l]                  = we_q[head_q][l] & ~wb_diswr & ~wb_flush;
                wb_dst[l*5 +: 5]          = dst_q[head_q][l];
                wb_data[l*DATA_W +: DATA_W] = data_q[head_q][l];
                wb_pc[l*32 +: 32]         = pc_q[head_q][l];
            end
        end
    end

`ifdef WB_QUEUE_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Youngest pending write per query: scan oldest->youngest, lanes low->high, last match wins.
    always_comb begin
        q_hit   = '0;
        q_data  = '0;
        fwd_idx = '0;
        for (int q = 0; q < NQ; q++) begin
            for (int k = 0; k < DEPTH; k++) begin
                fwd_idx = head_q + PTR_W'(k);
                if (CNT_W'(k) < cnt_q) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (we_q[fwd_idx][l] && (q_idx[q*5 +: 5] != 5'd0) &&
                            (dst_q[fwd_idx][l] == q_idx[q*5 +: 5])) begin
                            q_hit[q]                  = 1'b1;
                            q_data[q*DATA_W +: DATA_W] = data_q[fwd_idx][l];
                        end
                    end
                end
            end
        end
    end
`else
    logic unused_q_idx;

    assign unused_q_idx = ^q_idx;
    assign q_hit        = '0;
    assign q_data       = '0;
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// tb/tb_wb_commit_queue.sv - self-checking bench for wb_commit_queue
module tb_wb_commit_queue;

    localparam int LANES  = 2;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int NQ     = 2;

    logic                    clk = 1'b0;
    logic                    resetn;
    logic                    wb_flush;
    logic                    wb_diswr;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES-1:0]        in_lane_v;
    logic [LANES*32-1:0]     in_pc;
    logic [LANES*DATA_W-1:0] in_alu;
    logic [LANES*DATA_W-1:0] in_outb;
    logic [LANES*32-1:0]     in_dmout;
    logic [LANES*3-1:0]      in_ldtype;
    logic [LANES*2-1:0]      in_wbsel;
    logic [LANES*5-1:0]      in_dst;
    logic [LANES-1:0]        in_rfwr;
    logic [LANES-1:0]        wb_we;
    logic [LANES*5-1:0]      wb_dst;
    logic [LANES*DATA_W-1:0] wb_data;
    logic [LANES*32-1:0]     wb_pc;
    logic [$clog2(DEPTH):0]  q_count;
    logic [NQ*5-1:0]         q_idx;
    logic [NQ-1:0]           q_hit;
    logic [NQ*DATA_W-1:0]    q_data;

    always #5 clk = ~clk;

    wb_commit_queue #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH), .NQ(NQ)) dut (
        .clk(clk), .resetn(resetn), .wb_flush(wb_flush), .wb_diswr(wb_diswr),
        .in_valid(in_valid), .in_ready(in_ready), .in_lane_v(in_lane_v), .in_pc(in_pc),
        .in_alu(in_alu), .in_outb(in_outb), .in_dmout(in_dmout), .in_ldtype(in_ldtype),
        .in_wbsel(in_wbsel), .in_dst(in_dst), .in_rfwr(in_rfwr), .wb_we(wb_we),
        .wb_dst(wb_dst), .wb_data(wb_data), .wb_pc(wb_pc), .q_count(q_count),
        .q_idx(q_idx), .q_hit(q_hit), .q_data(q_data)
    );

    typedef struct packed {
        logic [LANES-1:0]        we;
        logic [LANES*5-1:0]      dst;
        logic [LANES*DATA_W-1:0] data;
        logic [LANES*32-1:0]     pc;
    } bundle_t;

    typedef struct {
        logic [2:0]  ldtype;
        logic [1:0]  wbsel;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] outb;
        logic [31:0] dmout;
        logic [4:0]  dst;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    bundle_t mq[$];
    vec_t    vt[10];
    int      n_checks = 0;
    int      n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] final_val(input logic [1:0] sel, input logic [2:0] lt,
                                              input logic [31:0] pc, input logic [31:0] alu,
                                              input logic [31:0] outb, input logic [31:0] dm);
        logic [31:0] b;
        logic [31:0] h;
        b = (dm >> (alu[1:0] * 8)) & 32'hFF;
        h = (dm >> (alu[1] * 16)) & 32'hFFFF;
        if (sel == 2'd0) return pc + 32'd8;
        if (sel == 2'd1) return alu;
        if (sel == 2'd2) return outb;
        case (lt)
            3'd1:    return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return dm;
        endcase
    endfunction

    function automatic bundle_t make_bundle();
        bundle_t     b;
        logic [31:0] claimed;
        logic [4:0]  d;
        b       = '0;
        claimed = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            d = in_dst[l*5 +: 5];
            b.dst[l*5 +: 5]           = d;
            b.pc[l*32 +: 32]          = in_pc[l*32 +: 32];
            b.data[l*DATA_W +: DATA_W] = final_val(in_wbsel[l*2 +: 2], in_ldtype[l*3 +: 3],
                                                   in_pc[l*32 +: 32], in_alu[l*DATA_W +: DATA_W],
                                                   in_outb[l*DATA_W +: DATA_W],
                                                   in_dmout[l*32 +: 32]);
            if (in_lane_v[l] && in_rfwr[l] && d != 0 && !claimed[d]) begin
                b.we[l]    = 1'b1;
                claimed[d] = 1'b1;
            end
        end
        return b;
    endfunction

    task automatic compare_all();
        int                   sz;
        logic [NQ-1:0]        eh;
        logic [NQ*DATA_W-1:0] ed;
        logic [4:0]           qi;
        sz = mq.size();
        check("in_ready", in_ready, sz < DEPTH);
        check("q_count", q_count, sz);
        check("wb_we", wb_we, (sz > 0 && !wb_diswr && !wb_flush) ? mq[0].we : '0);
        if (sz > 0) begin
            check("wb_dst", wb_dst, mq[0].dst);
            check("wb_data", wb_data, mq[0].data);
            check("wb_pc", wb_pc, mq[0].pc);
        end
        eh = '0;
        ed = '0;
        for (int q = 0; q < NQ; q++) begin
            qi = q_idx[q*5 +: 5];
            for (int k = 0; k < sz; k++) begin
                for (int l = 0; l < LANES; l++) begin
                    if (qi != 0 && mq[k].we[l] && mq[k].dst[l*5 +: 5] == qi) begin
                        eh[q]                  = 1'b1;
                        ed[q*DATA_W +: DATA_W] = mq[k].data[l*DATA_W +: DATA_W];
                    end
                end
            end
        end
`ifndef WB_QUEUE_FWD_EN
        eh = '0;
        ed = '0;
`endif
        check("q_hit", q_hit, eh);
        check("q_data", q_data, ed);
    endtask

    task automatic model_update();
        int      sz;
        bundle_t b;
        if (wb_flush) begin
            mq.delete();
        end else begin
            sz = mq.size();
            b  = make_bundle();
            if (sz > 0 && !wb_diswr) void'(mq.pop_front());
            if (in_valid && sz < DEPTH) mq.push_back(b);
        end
    endtask

    task automatic step();
        #1;
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic rand_lanes();
        for (int l = 0; l < LANES; l++) begin
            in_pc[l*32 +: 32]            = $urandom;
            in_alu[l*DATA_W +: DATA_W]   = $urandom;
            in_outb[l*DATA_W +: DATA_W]  = $urandom;
            in_dmout[l*32 +: 32]         = $urandom;
            in_ldtype[l*3 +: 3]          = 3'($urandom_range(0, 4));
            in_wbsel[l*2 +: 2]           = 2'($urandom_range(0, 3));
            in_dst[l*5 +: 5]             = 5'($urandom_range(0, 7));
        end
        in_lane_v = LANES'($urandom);
        in_rfwr   = LANES'($urandom);
    endtask

    task automatic set_lane(input int l, input logic [1:0] sel, input logic [31:0] alu,
                            input logic [4:0] dst);
        in_lane_v[l]               = 1'b1;
        in_rfwr[l]                 = 1'b1;
        in_wbsel[l*2 +: 2]         = sel;
        in_alu[l*DATA_W +: DATA_W] = alu;
        in_dst[l*5 +: 5]           = dst;
    endtask

    task automatic clear_inputs();
        in_valid  = 1'b0;
        in_lane_v = '0;
        in_pc     = '0;
        in_alu    = '0;
        in_outb   = '0;
        in_dmout  = '0;
        in_ldtype = '0;
        in_wbsel  = '0;
        in_dst    = '0;
        in_rfwr   = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{3'd1, 2'd3, 32'h0, 32'h0000_1002, 32'h0, 32'h0080_0000, 5'd5,  1'b1, 32'hFFFF_FF80};
        vt[1] = '{3'd2, 2'd3, 32'h0, 32'h0000_1002, 32'h0, 32'h0080_0000, 5'd5,  1'b1, 32'h0000_0080};
        vt[2] = '{3'd3, 2'd3, 32'h0, 32'h0000_2002, 32'h0, 32'h8001_1234, 5'd6,  1'b1, 32'hFFFF_8001};
        vt[3] = '{3'd4, 2'd3, 32'h0, 32'h0000_2002, 32'h0, 32'h8001_1234, 5'd6,  1'b1, 32'h0000_8001};
        vt[4] = '{3'd0, 2'd3, 32'h0, 32'h0000_0003, 32'h0, 32'hDEAD_BEEF, 5'd9,  1'b1, 32'hDEAD_BEEF};
        vt[5] = '{3'd1, 2'd3, 32'h0, 32'h0000_0000, 32'h0, 32'h1234_567F, 5'd10, 1'b1, 32'h0000_007F};
        vt[6] = '{3'd2, 2'd3, 32'h0, 32'h0000_0003, 32'h0, 32'hAB00_0000, 5'd11, 1'b1, 32'h0000_00AB};
        vt[7] = '{3'd0, 2'd0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 5'd31, 1'b1, 32'h0000_0004};
        vt[8] = '{3'd0, 2'd1, 32'h0, 32'hCAFE_F00D, 32'h0, 32'h0, 5'd12, 1'b1, 32'hCAFE_F00D};
        vt[9] = '{3'd0, 2'd2, 32'h0, 32'h0, 32'h1357_9BDF, 32'h0, 5'd0, 1'b0, 32'h1357_9BDF};

        resetn   = 1'b0;
        wb_flush = 1'b0;
        wb_diswr = 1'b0;
        q_idx    = '0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("rst_q_count", q_count, 0);
        check("rst_wb_we", wb_we, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_dst", wb_dst, 0);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            clear_inputs();
            in_valid          = 1'b1;
            in_lane_v         = 2'b01;
            in_rfwr           = 2'b01;
            in_ldtype[2:0]    = vt[i].ldtype;
            in_wbsel[1:0]     = vt[i].wbsel;
            in_pc[31:0]       = vt[i].pc;
            in_alu[31:0]      = vt[i].alu;
            in_outb[31:0]     = vt[i].outb;
            in_dmout[31:0]    = vt[i].dmout;
            in_dst[4:0]       = vt[i].dst;
            step();
            in_valid = 1'b0;
            #1;
            check("vec_we", wb_we, {1'b0, vt[i].exp_we});
            if (vt[i].exp_we) begin
                check("vec_dst", wb_dst[4:0], vt[i].dst);
                check("vec_data", wb_data[31:0], vt[i].exp_data);
            end
            step();
        end

        wb_diswr = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rand_lanes();
            in_valid = 1'b1;
            step();
        end
        #1;
        check("bp_full_count", q_count, DEPTH);
        check("bp_full_ready", in_ready, 0);
        check("bp_full_we", wb_we, 0);
        rand_lanes();
        step();
        in_valid = 1'b0;
        wb_diswr = 1'b0;
        step();
        #1;
        check("bp_ready_after_pop", in_ready, 1);
        repeat (DEPTH) step();

        wb_diswr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_lanes();
            in_valid = 1'b1;
            step();
        end
        rand_lanes();
        wb_flush = 1'b1;
        #1;
        check("flush_cycle_we", wb_we, 0);
        step();
        wb_flush = 1'b0;
        in_valid = 1'b0;
        wb_diswr = 1'b0;
        #1;
        check("flush_count", q_count, 0);
        for (int i = 0; i < 3; i++) begin
            check("flush_no_write", wb_we, 0);
            step();
        end

        clear_inputs();
        in_valid = 1'b1;
        set_lane(0, 2'd1, 32'h1111_0000, 5'd7);
        set_lane(1, 2'd1, 32'h2222_0000, 5'd7);
        step();
        in_valid = 1'b0;
        #1;
        check("waw_we", wb_we, 2'b10);
        check("waw_data", wb_data[63:32], 32'h2222_0000);
        check("waw_dst", wb_dst[9:5], 7);
        step();
        in_valid = 1'b1;
        set_lane(0, 2'd1, 32'h3333_0000, 5'd0);
        set_lane(1, 2'd1, 32'h4444_0000, 5'd0);
        step();
        in_valid = 1'b0;
        #1;
        check("dst0_we", wb_we, 0);
        step();

        wb_diswr = 1'b1;
        clear_inputs();
        in_valid = 1'b1;
        set_lane(0, 2'd1, 32'h11, 5'd3);
        step();
        clear_inputs();
        in_valid = 1'b1;
        set_lane(1, 2'd1, 32'h22, 5'd3);
        step();
        in_valid = 1'b0;
        q_idx    = {5'd0, 5'd3};
        #1;
`ifdef WB_QUEUE_FWD_EN
        check("fwd_hit", q_hit, 2'b01);
        check("fwd_data", q_data[31:0], 32'h22);
`else
        check("fwd_off_hit", q_hit, 0);
        check("fwd_off_data", q_data, 0);
`endif
        step();
        wb_diswr = 1'b0;
        repeat (2) step();
        q_idx = '0;

        wb_diswr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_lanes();
            in_valid = 1'b1;
            step();
        end
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_count", q_count, 0);
        check("midrst_we", wb_we, 0);
        check("midrst_data", wb_data, 0);
        check("midrst_pc", wb_pc, 0);
        mq.delete();
        @(negedge clk);
        in_valid = 1'b0;
        wb_diswr = 1'b0;
        resetn   = 1'b1;
        #1;
        check("midrst_release_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            check("midrst_no_spurious", wb_we, 0);
            step();
        end

        for (int i = 0; i < 400; i++) begin
            rand_lanes();
            in_valid = 1'($urandom_range(0, 3) != 0);
            wb_diswr = 1'($urandom_range(0, 9) < 3);
            wb_flush = 1'($urandom_range(0, 19) == 0);
            q_idx    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
